// File: rtl/dig_bcd_conv.sv
// dig_bcd_conv
// Sequential 32-bit binary to 8-digit packed BCD converter (double dabble,
// one bit per cycle) feeding the seven-segment digit driver.
//
// Ports:
//   dig_clk    clock
//   dig_rst    asynchronous active-high reset
//   in_valid   request valid; in_data sampled when in_valid && in_ready
//   in_data    32-bit unsigned value to convert
//   in_raw     (DIG_BCD_RAW_EN only) pass in_data through unconverted
//   in_ready   high only in IDLE
//   dig_we     one-cycle write strobe to the display driver
//   dig_wdata  packed BCD result, digit 0 in [3:0]; holds between strobes
//   busy       conversion in progress
//   ovf        last result saturated to 9999_9999; updates with dig_we
//
// Optional feature macro: DIG_BCD_RAW_EN (adds in_raw hex pass-through).
module dig_bcd_conv (
    input  logic        dig_clk,
    input  logic        dig_rst,
    input  logic        in_valid,
    input  logic [31:0] in_data,
`ifdef DIG_BCD_RAW_EN
    input  logic        in_raw,
`endif
    output logic        in_ready,
    output logic        dig_we,
    output logic [31:0] dig_wdata,
    output logic        busy,
    output logic        ovf
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] bin_q, bin_d;
    logic [39:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ovf_q, ovf_d;
    logic        we_q, we_d;
    logic        busy_q, busy_d;
    logic        raw_q, raw_d;
    logic        raw_req;
    logic [39:0] acc_adj;

`ifdef DIG_BCD_RAW_EN
    assign raw_req = in_raw;
`else
    assign raw_req = 1'b0;
`endif

    // Add-3 correction on all ten digits before the shift. A digit >= 5
    // becomes at most 4'hC, so no carry ever leaves the digit.
    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < 10; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5)
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        wdata_d = wdata_q;
        ovf_d   = ovf_q;
        raw_d   = raw_q;
        we_d    = 1'b0;
        busy_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    bin_d = in_data;
                    acc_d = 40'd0;
                    cnt_d = 5'd31;
                    raw_d = raw_req;
                    if (raw_req) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SHIFT;
                        busy_d  = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                {acc_d, bin_d} = {acc_adj[38:0], bin_q, 1'b0};
                if (cnt_q == 5'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d  = cnt_q - 5'd1;
                    busy_d = 1'b1;
                end
            end
            S_DONE: begin
                we_d    = 1'b1;
                state_d = S_IDLE;
                if (raw_q) begin
                    wdata_d = bin_q;
                    ovf_d   = 1'b0;
                end else if (acc_q[39:32] != 8'd0) begin
                    // More than eight digits: saturate the display.
                    wdata_d = 32'h9999_9999;
                    ovf_d   = 1'b1;
                end else begin
                    wdata_d = acc_q[31:0];
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge dig_clk or posedge dig_rst) begin
        if (dig_rst) begin
            state_q <= S_IDLE;
            bin_q   <= 32'd0;
            acc_q   <= 40'd0;
            cnt_q   <= 5'd0;
            wdata_q <= 32'd0;
            ovf_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            raw_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            ovf_q   <= ovf_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            raw_q   <= raw_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign dig_we    = we_q;
    assign dig_wdata = wdata_q;
    assign busy      = busy_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_dig_bcd_conv.sv
module tb_dig_bcd_conv;

    logic        dig_clk = 1'b0;
    logic        dig_rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
`ifdef DIG_BCD_RAW_EN
    logic        in_raw = 1'b0;
`endif
    logic        in_ready, dig_we, busy, ovf;
    logic [31:0] dig_wdata;

    int checks   = 0;
    int failures = 0;

    always #5 dig_clk = ~dig_clk;

    dig_bcd_conv u_dut (
        .dig_clk   (dig_clk),
        .dig_rst   (dig_rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
`ifdef DIG_BCD_RAW_EN
        .in_raw    (in_raw),
`endif
        .in_ready  (in_ready),
        .dig_we    (dig_we),
        .dig_wdata (dig_wdata),
        .busy      (busy),
        .ovf       (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One request; measures strobe latency and busy cycles, checks the
    // result and that outputs held still until the strobe.
    task automatic run(input string tag, input logic [31:0] v, input logic [31:0] exp_w,
                       input logic exp_o, input int exp_lat, input int exp_busy);
        int lat, bcnt;
        logic [31:0] w0;
        logic o0, stable;
        @(negedge dig_clk);
        w0 = dig_wdata; o0 = ovf; stable = 1'b1;
        in_valid = 1'b1; in_data = v;
        @(posedge dig_clk); #1;
        in_valid = 1'b0; in_data = 32'h0BAD_F00D;
        lat = 0; bcnt = 0;
        while (!dig_we && lat < 40) begin
            if (busy) bcnt++;
            if (dig_wdata !== w0 || ovf !== o0) stable = 1'b0;
            @(posedge dig_clk); #1;
            lat++;
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " busy_cycles"}, bcnt, exp_busy);
        chk({tag, " hold"}, {31'd0, stable}, 32'd1);
        chk({tag, " wdata"}, dig_wdata, exp_w);
        chk({tag, " ovf"}, {31'd0, ovf}, {31'd0, exp_o});
        chk({tag, " ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge dig_clk); #1;
        chk({tag, " we_single"}, {31'd0, dig_we}, 32'd0);
    endtask

    initial begin
        int pulses, t0, t1;
        logic [31:0] v0, v1;

        // Reset state
        #12;
        chk("rst in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst dig_we", {31'd0, dig_we}, 32'd0);
        chk("rst wdata", dig_wdata, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst ovf", {31'd0, ovf}, 32'd0);
        @(negedge dig_clk); dig_rst = 1'b0;

        run("zero", 32'd0, 32'h0000_0000, 1'b0, 33, 32);
        run("12345678", 32'h00BC_614E, 32'h1234_5678, 1'b0, 33, 32);
        run("99999999", 32'h05F5_E0FF, 32'h9999_9999, 1'b0, 33, 32);
        run("1e8", 32'h05F5_E100, 32'h9999_9999, 1'b1, 33, 32);
        run("max", 32'hFFFF_FFFF, 32'h9999_9999, 1'b1, 33, 32);

        // Reset 10 cycles into a conversion, asserted mid-cycle
        @(negedge dig_clk);
        in_valid = 1'b1; in_data = 32'h00BC_614E;
        @(posedge dig_clk); #1; in_valid = 1'b0;
        repeat (10) @(posedge dig_clk);
        #3; dig_rst = 1'b1; #1;
        chk("abort in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort wdata", dig_wdata, 32'd0);
        chk("abort ovf", {31'd0, ovf}, 32'd0);
        @(negedge dig_clk); dig_rst = 1'b0;
        pulses = 0;
        repeat (30) begin
            @(posedge dig_clk); #1;
            if (dig_we) pulses++;
        end
        chk("abort no_we", pulses, 0);
        run("305", 32'd305, 32'h0000_0305, 1'b0, 33, 32);

        // Back-to-back with in_valid held; data changes while busy
        @(negedge dig_clk);
        in_valid = 1'b1; in_data = 32'd7;
        @(posedge dig_clk); #1;
        in_data = 32'd42;
        pulses = 0; t0 = -1; t1 = -1; v0 = 32'd0; v1 = 32'd0;
        for (int e = 1; e <= 80; e++) begin
            @(posedge dig_clk); #1;
            if (e == 34) in_valid = 1'b0;
            if (dig_we) begin
                if (pulses == 0) begin t0 = e; v0 = dig_wdata; end
                else if (pulses == 1) begin t1 = e; v1 = dig_wdata; end
                pulses++;
            end
        end
        chk("b2b pulses", pulses, 2);
        chk("b2b first_edge", t0, 33);
        chk("b2b spacing", t1 - t0, 34);
        chk("b2b first_val", v0, 32'h0000_0007);
        chk("b2b second_val", v1, 32'h0000_0042);

`ifdef DIG_BCD_RAW_EN
        in_raw = 1'b1;
        run("raw", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1, 0);
        in_raw = 1'b0;
        run("after_raw", 32'h00BC_614E, 32'h1234_5678, 1'b0, 33, 32);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
